add_sub_arbiter: RTL
====================

Name: add_sub_arbiter

Overview:
Shares one add_sub unit (4-bit adder/subtractor: control=0 gives a+b, control=1 gives a−b, with carry-out) among N requesters. Each requester uses a valid/ready request channel. The block grants one request at a time by round-robin, registers the operands, drives the shared add_sub, and returns a registered, requester-tagged result on a single valid/ready response channel. It sits between the requesting control FSMs and the arithmetic datapath.

Parameters:
W, 4, operand/result width; must equal the add_sub width (4).
N, 2, number of requesters; legal range 2..8.
IDW, 3, width of the requester id on the response; must satisfy 2**IDW >= N.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
req_valid  in  N  bit i: requester i presents an operation.
req_ready  out  N  bit i: requester i's operation is accepted this cycle (one-hot or zero).
req_a  in  N*W  flattened operand a; requester i uses bits [i*W +: W].
req_b  in  N*W  flattened operand b, same packing.
req_op  in  N  bit i: 0 = add, 1 = subtract (drives add_sub control).
rsp_valid  out  1  response holds a result.
rsp_ready  in  1  consumer accepts the response.
rsp_result  out  W  a+b or a−b, modulo 2**W.
rsp_cout  out  1  add_sub carry-out; for subtract, 1 = no borrow (a>=b).
rsp_id  out  IDW  index of the requester that issued this operation.

Behaviour:
- States: IDLE, EXEC, RESP. On rst: state=IDLE, rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_id=0, req_ready=0, last_grant=N−1, operand registers=0.
- IDLE:
  - If any req_valid bit is set, grant g = first set bit searching upward from (last_grant+1) mod N, with wrap-around.
  - req_ready[g]=1 combinationally in that cycle only. All other req_ready bits are 0.
  - On the edge: capture a_q, b_q, op_q, id_q from requester g; last_grant←g; go to EXEC.
  - If no request, stay in IDLE with req_ready=0.
- EXEC:
  - add_sub inputs are a_q, b_q, op_q only, never the live request buses.
  - On the edge: rsp_result←result, rsp_cout←cout, rsp_id←id_q, rsp_valid←1; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid←0; go to IDLE.
  - req_ready=0. No new grant is issued in the same cycle as the handshake.
- Latency: accept edge → rsp_valid high 2 edges later (rsp_valid is high in cycle accept+2). Minimum 3 cycles per operation.
- Arithmetic: all W-bit modulo. Add: {cout,result}=a+b. Subtract: {cout,result}=a+~b+1.
- req_valid dropped by a requester before it is granted: its request is ignored, with no side effects. Operand changes while not granted are irrelevant.
- All N requesting continuously: grants cycle 0,1,…,N−1,0 strictly. No requester waits more than N−1 other grants.
- Single requester: it is granted every operation, regardless of last_grant.
- rst asserted in any state, including EXEC, or RESP with rsp_valid=1: the in-flight operation is discarded and all reset values apply on the next edge. No response is emitted for the discarded operation.
- rsp_ready high while rsp_valid=0: no effect.

Decomposition:
- Shared package: state encoding constants (S_IDLE=2'd0, S_EXEC=2'd1, S_RESP=2'd2) and op constants (OP_ADD=1'b0, OP_SUB=1'b1).
- One sub-module, rr_pick (N-bit round-robin priority picker: inputs req vector and last index; outputs grant index and any). This keeps the wrap-around search unit-testable.
- add_sub is instantiated once, unmodified.

Test Plan:
- Req0 only, a=7, b=5, op=0, rsp_ready=1 → req_ready[0] for 1 cycle; 2 cycles later rsp_valid=1, rsp_result=12, rsp_cout=0, rsp_id=0.
- Req1 only, a=3, b=5, op=1 → rsp_result=14, rsp_cout=0, rsp_id=1. Then a=5, b=3, op=1 → rsp_result=2, rsp_cout=1.
- Overflow: req0 a=9, b=9, op=0 → rsp_result=2, rsp_cout=1.
- Both requesters valid continuously after reset → grant order 0,1,0,1 over 4 operations; rsp_id sequence 0,1,0,1; each grant spaced 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable and req_ready=0 throughout. Raise rsp_ready → response consumed; next grant in the following cycle.
- Reset mid-operation: assert rst during EXEC → next cycle rsp_valid=0, state IDLE. The first grant after reset goes to req0 when both requesters are valid; the discarded operation is never reported.

Source files
------------

// File: rtl/add_sub_arbiter_pkg.sv
// Shared FSM state and operation encodings for the add_sub arbiter.
// No logic; imported by the arbiter and its bench.
package add_sub_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub.sv
// W-bit adder/subtractor: control=0 gives a+b, control=1 gives a-b (a+~b+1).
// Purely combinational; cout=1 on subtract means no borrow.
module add_sub #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         control,
  output logic [W-1:0] result,
  output logic         cout
);

  logic [W-1:0] b_eff;
  logic [W:0]   full;

  assign b_eff  = control ? ~b : b;
  assign full   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, control};
  assign result = full[W-1:0];
  assign cout   = full[W];

endmodule

// File: rtl/add_sub_arbiter_rr_pick.sv
// Round-robin picker: first set req bit searching upward from last+1, wrapping.
// Combinational, zero latency; grant is 0 when no request is present.
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] grant,
  output logic           any
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    // k runs to N so the previous winner is considered last
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/add_sub_arbiter.sv
// Shares one add_sub among N valid/ready requesters, round-robin, one op in flight.
// Accept edge -> rsp_valid two edges later; response held until rsp_ready, no grants meanwhile.
module add_sub_arbiter
  import add_sub_arbiter_pkg::*;
#(
  parameter int W   = 4,
  parameter int N   = 2,
  parameter int IDW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N-1:0]   req_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_cout,
  output logic [IDW-1:0] rsp_id
);

  state_t         state;
  logic [W-1:0]   a_q, b_q;
  logic           op_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant;
  logic           any;
  logic [W-1:0]   a_sel, b_sel;
  logic           op_sel;
  logic [W-1:0]   alu_result;
  logic           alu_cout;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant),
    .any   (any)
  );

  // Datapath sees only the captured operands, never the live request buses
  add_sub #(.W(W)) u_add_sub (
    .a       (a_q),
    .b       (b_q),
    .control (op_q),
    .result  (alu_result),
    .cout    (alu_cout)
  );

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant == IDW'(i)) begin
        a_sel  = req_a[i*W +: W];
        b_sel  = req_b[i*W +: W];
        op_sel = req_op[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && any) req_ready = N'(1) << grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= '0;
      last_grant <= IDW'(N - 1);
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      id_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any) begin
            a_q        <= a_sel;
            b_q        <= b_sel;
            op_q       <= op_sel;
            id_q       <= grant;
            last_grant <= grant;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_result <= alu_result;
          rsp_cout   <= alu_cout;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
